// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a two-entry elastic output stage
// (output register plus skid register) and a saturating illegal-opcode counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_type,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       ty;
        logic            ill;
    } entry_t;

    localparam bit RV64 = (XLEN == 64);

    entry_t dec;
    entry_t or_q;
    entry_t sr_q;
    logic   or_valid;
    logic   sr_valid;
    logic   or_free;
    logic   accept;
    logic   is_shift;

    assign is_shift = (inst_code[13:12] == 2'b01);  // funct3 001 or 101

    // NOTE: every field gets a default before the case so no path leaves a latch;
    // combinational logic uses blocking assignments only.
    always_comb begin
        dec.imm = '0;
        dec.ty  = IMM_NONE;
        dec.ill = 1'b0;
        case (inst_code[6:0])
            7'b0000011, 7'b1100111: begin
                dec.imm = XLEN'($signed(inst_code[31:20]));
                dec.ty  = IMM_I;
            end
            7'b0010011: begin
                if (is_shift) begin
                    dec.imm = RV64 ? XLEN'(inst_code[25:20]) : XLEN'(inst_code[24:20]);
                    dec.ty  = IMM_SHAMT;
                end else begin
                    dec.imm = XLEN'($signed(inst_code[31:20]));
                    dec.ty  = IMM_I;
                end
            end
            7'b0011011: begin
                if (!RV64) begin
                    dec.ill = 1'b1;
                end else if (is_shift) begin
                    dec.imm = XLEN'(inst_code[24:20]);
                    dec.ty  = IMM_SHAMT;
                end else begin
                    dec.imm = XLEN'($signed(inst_code[31:20]));
                    dec.ty  = IMM_I;
                end
            end
            7'b0100011: begin
                dec.imm = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
                dec.ty  = IMM_S;
            end
            7'b1100011: begin
                dec.imm = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                         inst_code[11:8], 1'b0}));
                dec.ty  = IMM_B;
            end
            7'b1101111: begin
                dec.imm = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                         inst_code[30:21], 1'b0}));
                dec.ty  = IMM_J;
            end
            7'b0110111, 7'b0010111: begin
                dec.imm = XLEN'($signed({inst_code[31:12], 12'b0}));
                dec.ty  = IMM_U;
            end
            7'b0111011:                         dec.ill = !RV64;
            7'b0110011, 7'b0001111, 7'b1110011: dec.ill = 1'b0;
            default:                            dec.ill = 1'b1;
        endcase
    end

    assign or_free  = !or_valid || out_ready;
    assign accept   = in_valid && !sr_valid;
    assign in_ready = !sr_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid    <= 1'b0;
            sr_valid    <= 1'b0;
            or_q        <= '0;
            illegal_cnt <= '0;
        end else begin
            if (flush) begin
                or_valid <= 1'b0;
                sr_valid <= 1'b0;
            end else if (or_free) begin
                if (sr_valid) begin
                    or_q     <= sr_q;
                    or_valid <= 1'b1;
                    sr_valid <= 1'b0;
                end else begin
                    or_valid <= accept;
                    if (accept) or_q <= dec;
                end
            end else if (accept) begin
                sr_valid <= 1'b1;
            end
            if (accept && !flush && dec.ill && !(&illegal_cnt))
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // NOTE: skid payload is not reset; it is only ever observed behind sr_valid.
    always_ff @(posedge clk) begin
        if (accept && !or_free) sr_q <= dec;
    end

    assign out_valid = or_valid;
    assign imm_out   = or_q.imm;
    assign imm_type  = or_q.ty;
    assign illegal   = or_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an RV32 instance and an RV64 (4-bit counter) instance with shared
// stimulus and compares both against an occupancy/queue reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst_code = '0;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_imm_out;
    logic [2:0]  a_imm_type;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_imm_out;
    logic [2:0]  b_imm_type;
    logic [3:0]  b_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .inst_code(inst_code), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .imm_out(a_imm_out), .imm_type(a_imm_type),
        .illegal(a_illegal), .illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .inst_code(inst_code), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .imm_out(b_imm_out), .imm_type(b_imm_type),
        .illegal(b_illegal), .illegal_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Immediate values from the ISA field definitions using signed arithmetic.
    function automatic void ref_dec(input int xlen, input logic [31:0] i,
                                    output logic [63:0] imm, output logic [2:0] ty,
                                    output logic ill);
        int     si;
        int     u;
        longint v;
        logic [2:0] f3;
        si  = i;
        f3  = i[14:12];
        v   = 0;
        ty  = 3'd0;
        ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h67: begin v = longint'(si >>> 20); ty = 3'd1; end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    v  = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
                    ty = 3'd6;
                end else begin
                    v = longint'(si >>> 20); ty = 3'd1;
                end
            end
            7'h1B: begin
                if (xlen != 64) ill = 1'b1;
                else if (f3 == 3'd1 || f3 == 3'd5) begin v = longint'(i[24:20]); ty = 3'd6; end
                else begin v = longint'(si >>> 20); ty = 3'd1; end
            end
            7'h23: begin v = longint'(si >>> 25) * 32 + longint'(i[11:7]); ty = 3'd2; end
            7'h63: begin
                v = i[31] ? -4096 : 0;
                v = v + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                ty = 3'd3;
            end
            7'h6F: begin
                v = i[31] ? -(longint'(1) << 20) : 0;
                v = v + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                ty = 3'd5;
            end
            7'h37, 7'h17: begin u = i & 32'hFFFF_F000; v = longint'(u); ty = 3'd4; end
            7'h3B:               ill = (xlen != 64);
            7'h33, 7'h0F, 7'h73: ill = 1'b0;
            default:             ill = 1'b1;
        endcase
        imm = v;
        if (xlen == 32) imm[63:32] = '0;
    endfunction

    task automatic compare_all();
        logic [63:0] imm;
        logic [2:0]  ty;
        logic        ill;
        check("a_out_valid", a_out_valid, q.size() > 0);
        check("b_out_valid", b_out_valid, q.size() > 0);
        check("a_in_ready", a_in_ready, q.size() < 2);
        check("b_in_ready", b_in_ready, q.size() < 2);
        check("a_illegal_cnt", a_cnt, cnt_a);
        check("b_illegal_cnt", b_cnt, cnt_b);
        if (q.size() > 0) begin
            ref_dec(32, q[0], imm, ty, ill);
            check("a_imm_out", a_imm_out, imm);
            check("a_imm_type", a_imm_type, ty);
            check("a_illegal", a_illegal, ill);
            ref_dec(64, q[0], imm, ty, ill);
            check("b_imm_out", b_imm_out, imm);
            check("b_imm_type", b_imm_type, ty);
            check("b_illegal", b_illegal, ill);
        end
    endtask

    // Called right after a rising edge with the inputs that edge sampled.
    task automatic model_update();
        logic [63:0] imm;
        logic [2:0]  ty;
        logic        ill;
        logic        acc;
        acc = in_valid && (q.size() < 2);
        if (acc && !flush) begin
            ref_dec(32, inst_code, imm, ty, ill);
            if (ill && cnt_a < 16'hFFFF) cnt_a++;
            ref_dec(64, inst_code, imm, ty, ill);
            if (ill && cnt_b < 4'hF) cnt_b++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(inst_code);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        inst_code = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        cnt_a = 0;
        cnt_b = 0;
        compare_all();
        check("rst_a_imm_out", a_imm_out, 64'h0);
        check("rst_a_imm_type", a_imm_type, 64'h0);
        check("rst_a_illegal", a_illegal, 64'h0);
        check("rst_b_imm_out", b_imm_out, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] INST_A = 32'hFFF0_0093;
    localparam logic [31:0] INST_B = 32'h1234_50B7;

    initial begin
        logic [6:0]  ops [13];
        logic [31:0] r;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F,
                7'h37, 7'h17, 7'h33, 7'h3B, 7'h0F, 7'h73};

        #1;
        compare_all();
        check("init_a_imm_out", a_imm_out, 64'h0);
        check("init_a_imm_type", a_imm_type, 64'h0);
        check("init_a_illegal", a_illegal, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, INST_A, 1'b1, 1'b0);
        check("addi_a_valid", a_out_valid, 64'h1);
        check("addi_a_imm", a_imm_out, 64'hFFFF_FFFF);
        check("addi_a_type", a_imm_type, 64'd1);
        check("addi_b_imm", b_imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, INST_B, 1'b1, 1'b0);
        check("lui_a_imm", a_imm_out, 64'h1234_5000);
        check("lui_a_type", a_imm_type, 64'd4);
        step(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
        check("beq_a_imm", a_imm_out, 64'hFFFF_FFFC);
        check("beq_a_type", a_imm_type, 64'd3);
        step(1'b1, 32'h03F0_1093, 1'b1, 1'b0);
        check("slli_b_imm", b_imm_out, 64'h3F);
        check("slli_b_type", b_imm_type, 64'd6);
        check("slli_a_imm", a_imm_out, 64'h1F);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: fill both slots, then drain in order
        step(1'b1, INST_A, 1'b0, 1'b0);
        check("bp_ready_after_a", a_in_ready, 64'h1);
        step(1'b1, INST_B, 1'b0, 1'b0);
        check("bp_ready_after_b", a_in_ready, 64'h0);
        check("bp_head_a", a_imm_out, 64'hFFFF_FFFF);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_head_b", a_imm_out, 64'h1234_5000);
        check("bp_ready_drain", a_in_ready, 64'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_empty", a_out_valid, 64'h0);

        // Illegal counting and saturation of the 4-bit counter
        step(1'b1, 32'h0, 1'b1, 1'b0);
        check("ill_flag", a_illegal, 64'h1);
        check("ill_imm", a_imm_out, 64'h0);
        check("ill_cnt1", a_cnt, 64'd1);
        for (int k = 0; k < 19; k++) step(1'b1, 32'h0, 1'b1, 1'b0);
        check("ill_sat_b", b_cnt, 64'hF);
        check("ill_cnt20_a", a_cnt, 64'd20);

        // Flush with both slots full and an illegal input presented
        step(1'b1, INST_A, 1'b0, 1'b0);
        step(1'b1, INST_B, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b1);
        check("flush_valid", a_out_valid, 64'h0);
        check("flush_ready", a_in_ready, 64'h1);
        check("flush_cnt", a_cnt, 64'd20);

        // Asynchronous reset with both slots full
        step(1'b1, INST_A, 1'b0, 1'b0);
        step(1'b1, INST_B, 1'b0, 1'b0);
        pulse_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("post_rst_valid", a_out_valid, 64'h0);
        step(1'b1, INST_B, 1'b0, 1'b0);
        check("post_rst_first", a_imm_out, 64'h1234_5000);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 12)];
            step($urandom_range(0, 9) < 7, r, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0);
            if (n == 1500) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the illegal-opcode counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  inst_code is presented.
REQ-006 SHALL have port in_ready  output  1  block accepts inst_code this cycle.
REQ-007 SHALL have port inst_code  input  32  raw RV instruction word.
REQ-008 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-009 SHALL have port out_valid  output  1  imm_out/imm_type/illegal are valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the output this cycle.
REQ-011 SHALL have port imm_out  output  XLEN  sign- or zero-extended immediate.
REQ-012 SHALL have port imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
REQ-013 SHALL have port illegal  output  1  opcode not in the supported set.
REQ-014 SHALL have port illegal_cnt  output  CNT_W  count of accepted illegal opcodes.

Function
REQ-015 Decode per opcode inst_code[6:0]: 0000011 load, 1100111 JALR -> I, sign-extend inst[31:20].
REQ-016 0010011 OP-IMM: funct3 001/101 -> SHAMT, zero-extend inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64); other funct3 -> I.
REQ-017 XLEN=64 only: 0000011 unchanged; 0011011 OP-IMM-32: funct3 001/101 -> SHAMT zero-extend inst[24:20], else I; XLEN=32 treats 0011011 as illegal.
REQ-018 0100011 -> S, sign-extend {inst[31:25],inst[11:7]}.
REQ-019 1100011 -> B, sign-extend {inst[31],inst[7],inst[30:25],inst[11:8],0}.
REQ-020 1101111 -> J, sign-extend {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-021 0110111 LUI, 0010111 AUIPC -> U, {inst[31:12],12'b0} sign-extended from bit 31 to XLEN.
REQ-022 0110011, 0111011 (XLEN=64), 0001111, 1110011 -> NONE, imm_out 0, illegal 0; any other opcode -> NONE, imm_out 0, illegal 1.
REQ-023 Datapath: output register (OR) plus one skid register (SR); decode occurs before capture; latency accept-to-out_valid exactly 1 cycle when OR is free.
REQ-024 Accept = in_valid & in_ready; in_ready = ~SR_valid (registered, no combinational path from out_ready).
REQ-025 On accept: if OR empty or OR consumed this cycle, and SR empty, entry goes to OR; otherwise to SR.
REQ-026 When OR consumed and SR full: SR moves to OR, SR empties; simultaneous accept that cycle is impossible (in_ready=0).
REQ-027 Outputs driven from OR only; OR contents stable while out_valid & ~out_ready.
REQ-028 Order of accepted instructions is preserved; no entry dropped or duplicated except by flush/reset.
REQ-029 flush: next cycle OR_valid=0, SR_valid=0; input accepted in the flush cycle is discarded and not counted; flush overrides all other updates.
REQ-030 illegal_cnt increments by 1 per accepted illegal instruction (at accept, not at output); saturates at all-ones; not cleared by flush.

Reset
REQ-031 rst_n low asynchronously clears OR_valid, SR_valid, illegal_cnt; out_valid=0, in_ready=1, imm_out=0, imm_type=0, illegal=0 while in reset.
REQ-032 Reset mid-operation discards all held entries; first accept after release behaves as from empty.

Verification
REQ-033 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm_out=0xFFFFFFFF, imm_type=1.
REQ-034 0x123450B7 (LUI) -> imm_out=0x12345000 type 4; 0xFE000EE3 (beq -4) -> 0xFFFFFFFC type 3; XLEN=64: 0x03F01093 (slli x1,x0,63) -> 0x3F type 6.
REQ-035 out_ready=0, accept A then B -> in_ready=0 after B; raise out_ready -> A then B on consecutive cycles, in_ready=1 after B drains.
REQ-036 inst 0x00000000 accepted -> imm_out=0, illegal=1, illegal_cnt=1; CNT_W=4 with 20 illegal accepts -> illegal_cnt=0xF.
REQ-037 OR and SR full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.
REQ-038 rst_n pulsed low mid-stream with both entries full -> out_valid=0, in_ready=1, illegal_cnt=0 immediately, no held entry appears after release.
